adc_block_averager: RTL and testbench

- Boxcar averager between the ADC capture interface and the enabled output register that holds each measurement point.
- After a start command it accepts exactly 2^L valid ADC samples, sums them, and divides by 2^L with a right shift.
- It then issues one result word with a single-cycle valid pulse.
- dout drives the register's data input; dout_valid drives its enable, so the register updates once per averaged point.

---
 rtl/adc_block_averager.sv | 84 ++++++++
 tb/tb_adc_block_averager.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/adc_block_averager.sv
// Boxcar averager: after start, sums 2^L valid ADC samples and emits the
// truncated mean (sum >> L) with a single-cycle valid pulse.
module adc_block_averager #(
    parameter int WIDTH    = 16,
    parameter int LOG2_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        len_log2,
    input  logic [WIDTH-1:0]  din,
    input  logic              din_valid,
    output logic [WIDTH-1:0]  dout,
    output logic              dout_valid,
    output logic              busy,
    output logic [LOG2_MAX:0] sample_cnt
);

    localparam int          AW   = WIDTH + LOG2_MAX;
    localparam logic [3:0]  LMAX = 4'(LOG2_MAX);

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t              state_q;
    logic [3:0]          l_q;
    logic [AW-1:0]       acc_q, acc_d;
    logic [LOG2_MAX:0]   cnt_q, cnt_d, target;
    logic [WIDTH-1:0]    dout_q, dout_d;
    logic                dv_q, busy_q, last;

    // Sum fits AW bits for every legal L, so the shifted mean always fits WIDTH.
    always_comb begin
        acc_d  = acc_q + AW'(din);
        cnt_d  = cnt_q + 1'b1;
        target = {{LOG2_MAX{1'b0}}, 1'b1} << l_q;
        last   = din_valid && (cnt_d == target);
        dout_d = WIDTH'(acc_d >> l_q);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            l_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            dv_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            dv_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        l_q     <= (len_log2 > LMAX) ? LMAX : len_log2;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (last) begin
                        dout_q  <= dout_d;
                        dv_q    <= 1'b1;
                        busy_q  <= 1'b0;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else if (din_valid) begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dv_q;
    assign busy       = busy_q;
    assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_adc_block_averager.sv
// Randomized bench for adc_block_averager against a queue-based reference
// that keeps the accepted samples of the open block and averages them on completion.
module tb_adc_block_averager;

    localparam int WIDTH    = 16;
    localparam int LOG2_MAX = 8;

    logic              clk = 1'b0;
    logic              rst, start, din_valid;
    logic [3:0]        len_log2;
    logic [WIDTH-1:0]  din;
    logic [WIDTH-1:0]  dout;
    logic              dout_valid, busy;
    logic [LOG2_MAX:0] sample_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    bit          m_active = 1'b0;
    int          m_L      = 0;
    int unsigned m_q[$];
    int          m_dout   = 0;
    bit          m_dv     = 1'b0;

    adc_block_averager #(.WIDTH(WIDTH), .LOG2_MAX(LOG2_MAX)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len_log2   (len_log2),
        .din        (din),
        .din_valid  (din_valid),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy),
        .sample_cnt (sample_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit s, input int len, input int d, input bit v);
        m_dv = 1'b0;
        if (!r) begin
            m_active = 1'b0;
            m_q.delete();
            m_dout = 0;
            m_L    = 0;
        end else if (!m_active) begin
            if (s) begin
                m_L      = (len > LOG2_MAX) ? LOG2_MAX : len;
                m_active = 1'b1;
                m_q.delete();
            end
        end else if (v) begin
            m_q.push_back(d & 'hFFFF);
            if (m_q.size() == (1 << m_L)) begin
                longint sum = 0;
                foreach (m_q[i]) sum += m_q[i];
                m_dout   = int'(sum / (longint'(1) << m_L));
                m_dv     = 1'b1;
                m_active = 1'b0;
                m_q.delete();
            end
        end
    endtask

    // One clock: apply inputs, advance the model on the edge, compare #1 later.
    task automatic cyc(input bit r, input bit s, input int len, input int d, input bit v);
        rst       = r;
        start     = s;
        len_log2  = 4'(len);
        din       = WIDTH'(d);
        din_valid = v;
        @(posedge clk);
        model_step(r, s, len, d, v);
        #1;
        check("dout",       dout,       m_dout);
        check("dout_valid", dout_valid, m_dv);
        check("busy",       busy,       m_active);
        check("sample_cnt", sample_cnt, m_q.size());
    endtask

    // Random gaps, random start pulses and len changes until the block closes.
    task automatic finish_block(input int gap_pct, input bit fixed_ff);
        int guard = 0;
        while (m_active && guard < 4000) begin
            bit v = ($urandom_range(0, 99) >= gap_pct);
            cyc(1, 1'($urandom_range(0, 1)), $urandom_range(0, 15),
                fixed_ff ? 'hFFFF : $urandom_range(0, 'hFFFF), v);
            guard++;
        end
        check("block_timeout", guard >= 4000, 0);
    endtask

    initial begin
        int pulses;
        repeat (3) cyc(0, 1, 3, 'h1234, 1);

        // L=2: 10,20,30,41 -> 25
        cyc(1, 1, 2, 99, 1);
        cyc(1, 0, 2, 10, 1);
        cyc(1, 0, 2, 20, 1);
        cyc(1, 0, 2, 30, 1);
        cyc(1, 0, 2, 41, 1);
        check("avg_L2", dout, 25);
        check("avg_L2_vld", dout_valid, 1);
        cyc(1, 0, 2, 0, 0);
        check("avg_L2_pulse_end", dout_valid, 0);

        // L=0: single sample passes straight through
        cyc(1, 1, 0, 0, 0);
        cyc(1, 0, 0, 'hABCD, 1);
        check("L0_dout", dout, 'hABCD);
        cyc(1, 0, 0, 0, 0);

        // L=8 full scale with gaps: exactly one pulse, no wrap
        cyc(1, 1, 8, 0, 0);
        pulses = 0;
        while (m_active) begin
            cyc(1, 0, 8, 'hFFFF, 1'($urandom_range(0, 2) != 0));
            pulses += int'(dout_valid);
        end
        check("L8_full_scale", dout, 'hFFFF);
        cyc(1, 0, 8, 0, 0);
        pulses += int'(dout_valid);
        check("L8_pulses", pulses, 1);

        // L=12 clamps to 256 samples; mid-block start/len noise ignored
        cyc(1, 1, 12, 0, 1);
        finish_block(30, 1'b0);
        cyc(1, 0, 0, 0, 0);

        // reset after 2 of 4 samples discards the block
        cyc(1, 1, 2, 0, 0);
        cyc(1, 0, 2, 50, 1);
        cyc(1, 0, 2, 60, 1);
        cyc(0, 0, 2, 70, 1);
        check("rst_dout", dout, 0);
        check("rst_busy", busy, 0);
        cyc(1, 0, 2, 0, 0);
        cyc(1, 1, 2, 0, 0);
        repeat (4) cyc(1, 0, 2, 4, 1);
        check("after_rst_avg", dout, 4);
        cyc(1, 0, 2, 0, 0);

        // start held high, L=1: 3,6 -> 4 then 8,9 -> 8; start-cycle samples ignored
        cyc(1, 1, 1, 100, 1);
        cyc(1, 1, 1, 3, 1);
        cyc(1, 1, 1, 6, 1);
        check("b2b_first", dout, 4);
        cyc(1, 1, 1, 77, 1);
        cyc(1, 1, 1, 8, 1);
        cyc(1, 1, 1, 9, 1);
        check("b2b_second", dout, 8);
        cyc(1, 0, 1, 0, 0);

        // random blocks
        for (int b = 0; b < 12; b++) begin
            cyc(1, 1, $urandom_range(0, 5), $urandom_range(0, 'hFFFF), 1'($urandom_range(0, 1)));
            finish_block($urandom_range(0, 60), 1'b0);
            repeat ($urandom_range(0, 2)) cyc(1, 0, 0, $urandom_range(0, 'hFFFF), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
